// File: rtl/lock_session_ctrl.sv
// ---------------------------------------------------------------------------
// lock_session_ctrl
//   Session controller in front of the 3-bit combination-lock datapath.
//   Up to NREQ keypad requesters share one code checker. Grants are handed
//   out round-robin, and each session walks through digit entry, a one-cycle
//   code check, and an open window. Consecutive failures are counted, and
//   MAX_FAIL of them in a row put the lock into a timed alarm lockout.
//
//   Optional feature: define LOCK_MASTER_CLR_EN to add the i_master_clr
//   input. In LOCKOUT it ends the lockout on the next cycle; in any other
//   state it only clears the failure count.
//
// Ports
//   i_clk        : clock, rising edge
//   i_reset      : synchronous, active-high reset
//   i_req        : per-requester session request (level)
//   i_dig_valid  : per-requester one-cycle digit strobe
//   i_dig        : per-requester digit, requester r on bits [3r+2:3r]
//   i_master_clr : (LOCK_MASTER_CLR_EN only) master clear of lockout/failures
//   o_grant      : one-hot session grant, zero when no session owns the checker
//   o_locked     : 1 = lock closed
//   o_alarm      : 1 during lockout
//   o_busy       : 1 whenever the controller is not idle
//   o_fail_cnt   : consecutive failed attempts
// ---------------------------------------------------------------------------
module lock_session_ctrl #(
  parameter int                    NREQ           = 2,
  parameter int                    CODE_LEN       = 4,
  parameter logic [3*CODE_LEN-1:0] CODE           = {3'd4, 3'd3, 3'd2, 3'd1},
  parameter int                    TIMEOUT        = 10,
  parameter int                    MAX_FAIL       = 3,
  parameter int                    OPEN_CYCLES    = 8,
  parameter int                    LOCKOUT_CYCLES = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_dig_valid,
  input  logic [3*NREQ-1:0]    i_dig,
`ifdef LOCK_MASTER_CLR_EN
  input  logic                 i_master_clr,
`endif
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_locked,
  output logic                 o_alarm,
  output logic                 o_busy,
  output logic [1:0]           o_fail_cnt
);

  localparam int TMR_MAX0 = (TIMEOUT > OPEN_CYCLES) ? TIMEOUT : OPEN_CYCLES;
  localparam int TMR_MAX  = (TMR_MAX0 > LOCKOUT_CYCLES) ? TMR_MAX0 : LOCKOUT_CYCLES;
  localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IDX_W    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int PTR_W    = $clog2(NREQ);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]       FAIL_LAST = 2'(MAX_FAIL - 1);
  localparam logic [1:0]       FAIL_MAX  = 2'(MAX_FAIL);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT} stateType;

  stateType          r_state;
  stateType          w_nextState;
  logic [NREQ-1:0]   r_grant;
  logic [PTR_W-1:0]  r_rrPtr;
  logic [IDX_W-1:0]  r_idx;
  logic [TMR_W-1:0]  r_timer;
  logic              r_mismatch;
  logic [1:0]        r_failCnt;

  logic              w_found;
  logic [NREQ-1:0]   w_winnerOneHot;
  logic [PTR_W-1:0]  w_nextPtr;
  logic              w_grantReq;
  logic              w_grantValid;
  logic [2:0]        w_grantDig;
  logic [2:0]        w_codeDigit;
  logic              w_masterClr;

`ifdef LOCK_MASTER_CLR_EN
  assign w_masterClr = i_master_clr;
`else
  assign w_masterClr = 1'b0;
`endif

  // Round-robin arbiter: scan from r_rrPtr upward, wrapping modulo NREQ,
  // and take the first active request. The pointer then moves one past the
  // winner, so whoever was just served has the lowest priority next time.
  always_comb begin
    w_found        = 1'b0;
    w_winnerOneHot = '0;
    w_nextPtr      = r_rrPtr;
    for (int off = 0; off < NREQ; off++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!w_found && i_req[r] && (r == (int'(r_rrPtr) + off) % NREQ)) begin
          w_found           = 1'b1;
          w_winnerOneHot[r] = 1'b1;
          w_nextPtr         = PTR_W'((r + 1) % NREQ);
        end
      end
    end
  end

  // Only the granted requester's keypad is seen by the checker. This block
  // also picks out the expected digit for the current entry position.
  always_comb begin
    w_grantReq   = |(i_req & r_grant);
    w_grantValid = |(i_dig_valid & r_grant);
    w_grantDig   = '0;
    w_codeDigit  = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (r_grant[r]) w_grantDig = i_dig[3*r +: 3];
    end
    for (int k = 0; k < CODE_LEN; k++) begin
      if (r_idx == IDX_W'(k)) w_codeDigit = CODE[3*k +: 3];
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic. A dropped request aborts entry before any digit in
  // the same cycle is considered.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = ENTRY;
      ENTRY: begin
        if (!w_grantReq)                              w_nextState = IDLE;
        else if (w_grantValid && r_idx == LAST_IDX)   w_nextState = CHECK;
        else if (!w_grantValid && r_timer == TO_LAST) w_nextState = CHECK;
      end
      CHECK: begin
        if (!r_mismatch)                w_nextState = OPEN;
        else if (r_failCnt == FAIL_LAST) w_nextState = LOCKOUT;
        else                            w_nextState = IDLE;
      end
      OPEN:    if (r_timer == OPEN_LAST) w_nextState = IDLE;
      LOCKOUT: if (r_timer == LOCK_LAST || w_masterClr) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register. The grant and the
  // failure count come straight from their own registers.
  always_comb begin
    o_locked   = (r_state != OPEN);
    o_alarm    = (r_state == LOCKOUT);
    o_busy     = (r_state != IDLE);
    o_grant    = r_grant;
    o_fail_cnt = r_failCnt;
  end

  // Session datapath. One timer is shared by ENTRY, OPEN and LOCKOUT and is
  // cleared on every state change. A timeout marks the attempt as a
  // mismatch, so CHECK treats it like a wrong code.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_grant    <= '0;
      r_rrPtr    <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_mismatch <= 1'b0;
      r_failCnt  <= '0;
    end else begin
      if (w_nextState != r_state) begin
        r_timer <= '0;
      end else begin
        case (r_state)
          ENTRY:         r_timer <= w_grantValid ? '0 : r_timer + 1'b1;
          OPEN, LOCKOUT: r_timer <= r_timer + 1'b1;
          default:       r_timer <= '0;
        endcase
      end

      case (r_state)
        IDLE: begin
          r_idx      <= '0;
          r_mismatch <= 1'b0;
          if (w_found) begin
            r_grant <= w_winnerOneHot;
            r_rrPtr <= w_nextPtr;
          end
        end
        ENTRY: begin
          if (!w_grantReq) begin
            r_grant <= '0;
          end else if (w_grantValid) begin
            r_mismatch <= r_mismatch | (w_grantDig != w_codeDigit);
            if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
          end else if (r_timer == TO_LAST) begin
            r_mismatch <= 1'b1;
          end
        end
        CHECK: begin
          r_grant <= '0;
          if (!r_mismatch)                 r_failCnt <= '0;
          else if (r_failCnt == FAIL_LAST) r_failCnt <= FAIL_MAX;
          else                             r_failCnt <= r_failCnt + 1'b1;
        end
        LOCKOUT: begin
          if (w_nextState == IDLE) r_failCnt <= '0;
        end
        default: ;
      endcase

      if (w_masterClr) r_failCnt <= '0;
    end
  end

endmodule

// File: tb/tb_lock_session_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lock_session_ctrl
//   Directed testbench for lock_session_ctrl with default parameters
//   (NREQ=2, code 1,2,3,4, TIMEOUT=10, MAX_FAIL=3, OPEN=8, LOCKOUT=20).
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_lock_session_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] digValid;
  logic [5:0] dig;
`ifdef LOCK_MASTER_CLR_EN
  logic       masterClr;
`endif
  logic [1:0] grant;
  logic       locked;
  logic       alarm;
  logic       busy;
  logic [1:0] failCnt;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [11:0] GOOD_CODE = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [11:0] BAD_CODE  = {3'd4, 3'd5, 3'd2, 3'd1};

  lock_session_ctrl dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_dig_valid  (digValid),
    .i_dig        (dig),
`ifdef LOCK_MASTER_CLR_EN
    .i_master_clr (masterClr),
`endif
    .o_grant      (grant),
    .o_locked     (locked),
    .o_alarm      (alarm),
    .o_busy       (busy),
    .o_fail_cnt   (failCnt)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] v,
                               input logic [5:0] d);
    req      = r;
    digValid = v;
    dig      = d;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkStatus(input string tag, input logic [1:0] g, input logic l,
                             input logic a, input logic b, input logic [1:0] f);
    checkOutput({tag, ".grant"},  32'(grant),   32'(g));
    checkOutput({tag, ".locked"}, 32'(locked),  32'(l));
    checkOutput({tag, ".alarm"},  32'(alarm),   32'(a));
    checkOutput({tag, ".busy"},   32'(busy),    32'(b));
    checkOutput({tag, ".fail"},   32'(failCnt), 32'(f));
  endtask

  // Requester 0 asks for a session and strobes four digits back to back.
  // Returns with the controller in CHECK.
  task automatic runSession(input logic [11:0] code);
    logic [11:0] c;
    c = code;
    applyStimulus(2'b01, 2'b00, 6'd0);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 2'b01, {3'd0, c[3*i +: 3]});
      tick(1);
    end
    applyStimulus(2'b01, 2'b00, 6'd0);
  endtask

  initial begin
    reset = 1'b1;
`ifdef LOCK_MASTER_CLR_EN
    masterClr = 1'b0;
`endif
    applyStimulus(2'b00, 2'b00, 6'd0);
    tick(2);
    checkStatus("reset", 2'b00, 1, 0, 0, 2'd0);
    reset = 1'b0;
    tick(1);

    // Good code from requester 0.
    applyStimulus(2'b01, 2'b00, 6'd0);
    tick(1);
    checkStatus("t1.grant", 2'b01, 1, 0, 1, 2'd0);
    for (int d = 1; d <= 4; d++) begin
      applyStimulus(2'b01, 2'b01, 6'(d));
      tick(1);
    end
    checkStatus("t1.check", 2'b01, 1, 0, 1, 2'd0);
    applyStimulus(2'b00, 2'b00, 6'd0);
    tick(1);
    checkStatus("t1.open", 2'b00, 0, 0, 1, 2'd0);
    tick(7);
    checkOutput("t1.open8.locked", 32'(locked), 32'd0);
    tick(1);
    checkStatus("t1.close", 2'b00, 1, 0, 0, 2'd0);

    // Simultaneous requests from reset, with foreign strobes ignored.
    reset = 1'b1;
    applyStimulus(2'b11, 2'b00, 6'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    checkOutput("t2.grant0", 32'(grant), 32'b01);
    for (int d = 1; d <= 4; d++) begin
      applyStimulus(2'b11, 2'b10, {3'(d), 3'd0});
      tick(1);
    end
    applyStimulus(2'b11, 2'b00, 6'd0);
    tick(1);
    checkStatus("t2.ignored", 2'b01, 1, 0, 1, 2'd0);
    for (int d = 1; d <= 4; d++) begin
      applyStimulus(2'b11, 2'b01, {3'd7, 3'(d)});
      tick(1);
    end
    applyStimulus(2'b11, 2'b00, 6'd0);
    checkOutput("t2.check.grant", 32'(grant), 32'b01);
    tick(1);
    checkStatus("t2.open", 2'b00, 0, 0, 1, 2'd0);
    tick(8);
    checkStatus("t2.idle", 2'b00, 1, 0, 0, 2'd0);
    tick(1);
    checkOutput("t2.grant1", 32'(grant), 32'b10);
    applyStimulus(2'b00, 2'b00, 6'd0);
    tick(1);
    checkStatus("t2.abort", 2'b00, 1, 0, 0, 2'd0);

    // Three wrong codes lead to lockout.
    runSession(BAD_CODE);
    tick(1);
    checkStatus("t3.fail1", 2'b00, 1, 0, 0, 2'd1);
    runSession(BAD_CODE);
    tick(1);
    checkStatus("t3.fail2", 2'b00, 1, 0, 0, 2'd2);
    runSession(BAD_CODE);
    tick(1);
    checkStatus("t3.lock", 2'b00, 1, 1, 1, 2'd3);
    tick(19);
    checkStatus("t3.lock20", 2'b00, 1, 1, 1, 2'd3);
    tick(1);
    checkStatus("t3.unlock", 2'b00, 1, 0, 0, 2'd0);
    applyStimulus(2'b00, 2'b00, 6'd0);
    tick(2);

    // Entry timeout after one digit.
    applyStimulus(2'b01, 2'b00, 6'd0);
    tick(1);
    applyStimulus(2'b01, 2'b01, 6'd1);
    tick(1);
    applyStimulus(2'b01, 2'b00, 6'd0);
    tick(9);
    checkStatus("t4.wait9", 2'b01, 1, 0, 1, 2'd0);
    tick(1);
    checkStatus("t4.check", 2'b01, 1, 0, 1, 2'd0);
    applyStimulus(2'b00, 2'b00, 6'd0);
    tick(1);
    checkStatus("t4.fail", 2'b00, 1, 0, 0, 2'd1);

    // Abort by dropping req, with a same-cycle digit that must be ignored.
    applyStimulus(2'b01, 2'b00, 6'd0);
    tick(1);
    applyStimulus(2'b01, 2'b01, 6'd1);
    tick(1);
    applyStimulus(2'b01, 2'b01, 6'd2);
    tick(1);
    applyStimulus(2'b00, 2'b01, 6'd3);
    tick(1);
    checkStatus("t5.abort", 2'b00, 1, 0, 0, 2'd1);

    // Abort by reset mid-entry.
    applyStimulus(2'b01, 2'b00, 6'd0);
    tick(1);
    checkOutput("t5.regrant", 32'(grant), 32'b01);
    applyStimulus(2'b01, 2'b01, 6'd1);
    tick(1);
    applyStimulus(2'b01, 2'b01, 6'd2);
    tick(1);
    reset = 1'b1;
    applyStimulus(2'b01, 2'b00, 6'd0);
    tick(1);
    checkStatus("t5.reset", 2'b00, 1, 0, 0, 2'd0);
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 6'd0);
    tick(1);

`ifdef LOCK_MASTER_CLR_EN
    // Master clear ends a lockout early.
    for (int n = 0; n < 3; n++) begin
      runSession(BAD_CODE);
      tick(1);
    end
    checkStatus("t6.lock", 2'b00, 1, 1, 1, 2'd3);
    applyStimulus(2'b00, 2'b00, 6'd0);
    tick(2);
    masterClr = 1'b1;
    tick(1);
    masterClr = 1'b0;
    checkStatus("t6.clear", 2'b00, 1, 0, 0, 2'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
